// File: rtl/my_pkg.sv
// Shared definitions for the layer instruction path.
//   INSTRUCTION_LENGTH / OPCODE_LENGTH / ADDR_LENGTH : instruction word layout,
//     opcode sits directly above the address field.
//   OP_LOAD / OP_STOP : opcodes the sequencer reacts to.
//   seq_state_t       : instr_sequencer FSM states.
package my_pkg;

  localparam int INSTRUCTION_LENGTH = 24;
  localparam int OPCODE_LENGTH      = 3;
  localparam int ADDR_LENGTH        = 16;

  localparam logic [OPCODE_LENGTH-1:0] OP_LOAD = 3'b010;
  localparam logic [OPCODE_LENGTH-1:0] OP_STOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } seq_state_t;

  function automatic logic [OPCODE_LENGTH-1:0] get_opcode(
    input logic [INSTRUCTION_LENGTH-1:0] word
  );
    return word[ADDR_LENGTH +: OPCODE_LENGTH];
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches a layer program from a synchronous instruction
// memory and issues one instruction per cycle to the decoder.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, base_pc : begin a layer at base_pc (only honoured while idle)
//   imem_en        : memory read enable (memory holds rdata while low)
//   imem_addr      : read address, always the pc register
//   imem_rdata     : read data, one cycle after an enabled read
//   load_busy      : load unit cannot take a load this cycle
//   instruction    : registered instruction to the decoder, zero = NOP
//   layer_done     : pulse aligned with the issued stop instruction
//   busy           : sequencer is not idle
//   overrun        : sticky, program ran past the last address without stop
module instr_sequencer
  import my_pkg::*;
#(
  parameter  int PROG_DEPTH = 256,
  localparam int PC_WIDTH   = $clog2(PROG_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [PC_WIDTH-1:0]           base_pc,
  output logic                          imem_en,
  output logic [PC_WIDTH-1:0]           imem_addr,
  input  logic [INSTRUCTION_LENGTH-1:0] imem_rdata,
  input  logic                          load_busy,
  output logic [INSTRUCTION_LENGTH-1:0] instruction,
  output logic                          layer_done,
  output logic                          busy,
  output logic                          overrun
);

  localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_DEPTH - 1);

  seq_state_t                    state_q, state_d;
  logic [PC_WIDTH-1:0]           pc_q, pc_d;
  // Set when the word now (or next) in imem_rdata was read from LAST_PC.
  // pc itself parks at LAST_PC instead of wrapping.
  logic                          at_end_q, at_end_d;
  logic [INSTRUCTION_LENGTH-1:0] instruction_q, instruction_d;
  logic                          layer_done_q, layer_done_d;
  logic                          overrun_q, overrun_d;
  logic [OPCODE_LENGTH-1:0]      opcode;

  assign opcode = get_opcode(imem_rdata);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    at_end_d      = at_end_q;
    instruction_d = '0;
    layer_done_d  = 1'b0;
    overrun_d     = overrun_q;
    imem_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d      = base_pc;
          at_end_d  = 1'b0;
          overrun_d = 1'b0;
          state_d   = PRIME;
        end
      end

      PRIME: begin
        imem_en = 1'b1;
        if (pc_q == LAST_PC) at_end_d = 1'b1;
        else                 pc_d     = pc_q + PC_WIDTH'(1);
        state_d = RUN;
      end

      RUN: begin
        if (opcode == OP_LOAD && load_busy) begin
          // Stall: NOP out, memory holds the load word for re-evaluation.
          instruction_d = '0;
        end else if (opcode == OP_STOP) begin
          instruction_d = imem_rdata;
          layer_done_d  = 1'b1;
          state_d       = IDLE;
        end else if (at_end_q) begin
          instruction_d = imem_rdata;
          overrun_d     = 1'b1;
          state_d       = IDLE;
        end else begin
          instruction_d = imem_rdata;
          imem_en       = 1'b1;
          if (pc_q == LAST_PC) at_end_d = 1'b1;
          else                 pc_d     = pc_q + PC_WIDTH'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      at_end_q      <= 1'b0;
      instruction_q <= '0;
      layer_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      at_end_q      <= at_end_d;
      instruction_q <= instruction_d;
      layer_done_q  <= layer_done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instruction = instruction_q;
  assign layer_done  = layer_done_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule
